// File: rtl/user_id_rom_scheduler.sv
// user_id_rom_scheduler
//   Shares the single-port registered user-ID ROM between two requesters and
//   owns the ROM address bus.
//   Port 0 (login path): searches the ROM for an ID; returns hit/index/word.
//   Port 1 (display path): reads one ROM word by address.
//
// Ports
//   clock, rst            rising-edge clock, synchronous active-high reset
//   req0_valid/id/ready   port-0 search request (transfer on valid & ready)
//   req1_valid/addr/ready port-1 read request
//   rom_addr, rom_data    ROM address out; data returns one cycle later
//   rsp_valid             one-cycle response pulse (no backpressure)
//   rsp_port/hit/index/data  registered response fields, held until next response
//   busy                  FSM not idle
//   locked                port-0 lockout active
//
// Build option: define LOOKUP_LOCKOUT_EN to lock port 0 out for LOCK_CYCLES
// cycles after MAX_FAIL consecutive search misses. Without it, locked is 0.
//
// state | meaning
// IDLE  | ready for a request, round-robin arbitration
// SCAN  | port-0 search, one address issued per cycle, compare one cycle later
// READ  | port-1 read, address issued then data captured
// RESP  | rsp_valid pulse, one cycle
module user_id_rom_scheduler #(
    parameter int ID_W        = 16,
    parameter int ADDR_W      = 3,
    parameter int NUM_ENTRIES = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ID_W-1:0]   req0_id,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ID_W-1:0]   rom_data,
    output logic              rsp_valid,
    output logic              rsp_port,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_index,
    output logic [ID_W-1:0]   rsp_data,
    output logic              busy,
    output logic              locked
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_ENTRIES);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_READ, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_port_q, rsp_port_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [ADDR_W-1:0] rsp_index_q, rsp_index_d;
    logic [ID_W-1:0]   rsp_data_q, rsp_data_d;

    logic              lock_active;
    logic              req0_ok;
    logic              scan_match;
    logic [ADDR_W-1:0] scan_idx;

    assign req0_ok    = req0_valid && !lock_active;
    // An all-zero ROM word is an empty slot and must never match.
    assign scan_match = (rom_data == id_q) && (rom_data != '0);
    // cnt_q counts SCAN cycles; the word on rom_data belongs to address cnt_q-1.
    assign scan_idx   = ADDR_W'(cnt_q - 1'b1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rom_addr_d   = rom_addr_q;
        rsp_valid_d  = 1'b0;
        rsp_port_d   = rsp_port_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_index_d  = rsp_index_q;
        rsp_data_d   = rsp_data_q;
        unique case (state_q)
            ST_IDLE: begin
                // Tie goes to the port that was not granted last.
                if (req0_ok && (!req1_valid || last_grant_q)) begin
                    state_d      = ST_SCAN;
                    last_grant_d = 1'b0;
                    id_d         = req0_id;
                    rom_addr_d   = '0;
                    cnt_d        = '0;
                end else if (req1_valid) begin
                    state_d      = ST_READ;
                    last_grant_d = 1'b1;
                    rom_addr_d   = req1_addr;
                    cnt_d        = '0;
                end
            end
            ST_SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if ((cnt_q != '0) && scan_match) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_port_d  = 1'b0;
                    rsp_hit_d   = 1'b1;
                    rsp_index_d = scan_idx;
                    rsp_data_d  = rom_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_port_d  = 1'b0;
                    rsp_hit_d   = 1'b0;
                    rsp_index_d = '0;
                    rsp_data_d  = '0;
                end
                // Issue runs ahead of compare; it parks on the last entry.
                if ((state_d == ST_SCAN) && (rom_addr_q != ADDR_LAST)) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                end
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_port_d  = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_index_d = rom_addr_q;
                    rsp_data_d  = rom_data;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= '0;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_port_q   <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_index_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_port_q   <= rsp_port_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_index_q  <= rsp_index_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

`ifdef LOOKUP_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (locked_q) begin
            if (lock_cnt_q == '0) begin
                locked_d = 1'b0;
            end else begin
                lock_cnt_d = lock_cnt_q - 1'b1;
            end
        end
        // Port 0 cannot be granted while locked, so this never overlaps the countdown.
        if ((state_q == ST_RESP) && !rsp_port_q) begin
            if (rsp_hit_q) begin
                fail_cnt_d = '0;
            end else if (fail_cnt_q == FAIL_W'(MAX_FAIL - 1)) begin
                fail_cnt_d = '0;
                locked_d   = 1'b1;
                lock_cnt_d = LOCK_W'(LOCK_CYCLES - 1);
            end else begin
                fail_cnt_d = fail_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign lock_active = locked_q;
`else
    // Lockout parameters only matter when the feature is built in.
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{MAX_FAIL, LOCK_CYCLES};
    assign lock_active     = 1'b0;
`endif

    assign req0_ready = (state_q == ST_IDLE) && !lock_active;
    assign req1_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign locked     = lock_active;
    assign rom_addr   = rom_addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_port   = rsp_port_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_index  = rsp_index_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_user_id_rom_scheduler.sv
// Bench for user_id_rom_scheduler: directed scenarios plus randomized traffic,
// checked against a behavioural model of search/read results and latencies.
module tb_user_id_rom_scheduler;
    localparam int ID_W        = 16;
    localparam int ADDR_W      = 3;
    localparam int NUM_ENTRIES = 8;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 1000;
    localparam int RSP_BUDGET  = 20;

    logic              clock      = 1'b0;
    logic              rst        = 1'b1;
    logic              req0_valid = 1'b0;
    logic [ID_W-1:0]   req0_id    = '0;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr  = '0;
    logic [ID_W-1:0]   rom_data   = '0;
    logic              req0_ready, req1_ready, rsp_valid, rsp_port, rsp_hit, busy, locked;
    logic [ADDR_W-1:0] rom_addr, rsp_index;
    logic [ID_W-1:0]   rsp_data;

    logic [ID_W-1:0]   rom_mem [NUM_ENTRIES];
    logic [ADDR_W-1:0] walk_q [$];

    int n_pass = 0;
    int n_chk  = 0;
    int m_last = 1;
    int m_fail = 0;
    bit m_locked = 1'b0;
    int lock_run = 0;
    int last_lock_len = 0;

    user_id_rom_scheduler #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .NUM_ENTRIES(NUM_ENTRIES),
        .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clock(clock), .rst(rst),
        .req0_valid(req0_valid), .req0_id(req0_id), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_hit(rsp_hit),
        .rsp_index(rsp_index), .rsp_data(rsp_data),
        .busy(busy), .locked(locked)
    );

    always #5 clock = ~clock;

    // Registered single-port ROM.
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    // Length of the most recent run of locked cycles.
    always @(negedge clock) begin
        if (!locked) lock_run = 0;
        else begin
            lock_run++;
            last_lock_len = lock_run;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Search result from the ROM contents: lowest matching non-empty index.
    task automatic ref_search(input logic [ID_W-1:0] id, output bit hit, output int idx,
                              output logic [ID_W-1:0] data, output int lat);
        hit = 1'b0; idx = 0; data = '0; lat = NUM_ENTRIES + 2;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && id != '0 && rom_mem[i] == id) begin
                hit = 1'b1; idx = i; data = id; lat = i + 3;
            end
        end
    endtask

    // Counts cycles from the accept cycle until rsp_valid (bounded).
    task automatic wait_rsp(input bit keep1, output int n);
        walk_q.delete();
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                req0_valid = 1'b0;
                req0_id    = ID_W'($urandom);
                if (!keep1) begin
                    req1_valid = 1'b0;
                    req1_addr  = ADDR_W'($urandom);
                end
            end
            walk_q.push_back(rom_addr);
        end while (!rsp_valid && n <= RSP_BUDGET);
    endtask

    task automatic run_txn(input bit v0, input bit v1, input logic [ID_W-1:0] id,
                           input logic [ADDR_W-1:0] addr, input bit chk_walk);
        int win, n, e_idx, e_lat;
        bit e_hit, e_lock, ok0;
        logic [ID_W-1:0] e_data;
        logic [31:0] w;
        @(negedge clock);
        ok0 = v0 && !m_locked;
        if (ok0 && v1) win = (m_last == 1) ? 0 : 1;
        else if (ok0)  win = 0;
        else           win = 1;
        req0_valid = v0; req1_valid = v1; req0_id = id; req1_addr = addr;
        #1;
        check_val("req0_ready", 32'(req0_ready), 32'(!m_locked));
        check_val("req1_ready", 32'(req1_ready), 32'd1);
        if (win == 0) ref_search(id, e_hit, e_idx, e_data, e_lat);
        else begin
            e_hit = 1'b1; e_idx = int'(addr); e_data = rom_mem[addr]; e_lat = 3;
        end
        m_last = win;
        wait_rsp(1'b0, n);
        check_val("rsp_latency", 32'(n), 32'(e_lat));
        check_val("rsp_port", 32'(rsp_port), 32'(win));
        check_val("rsp_hit", 32'(rsp_hit), 32'(e_hit));
        check_val("rsp_index", 32'(rsp_index), 32'(e_idx));
        check_val("rsp_data", 32'(rsp_data), 32'(e_data));
        if (chk_walk) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                w = (k < walk_q.size()) ? 32'(walk_q[k]) : 32'hFFFF_FFFF;
                check_val("rom_addr_walk", w, 32'(k));
            end
        end
        e_lock = 1'b0;
        if (win == 0) begin
            if (e_hit) m_fail = 0;
            else m_fail++;
`ifdef LOOKUP_LOCKOUT_EN
            if (m_fail == MAX_FAIL) begin
                e_lock = 1'b1;
                m_fail = 0;
            end
`endif
        end
        @(negedge clock);
        #1;
        check_val("rsp_pulse_width", 32'(rsp_valid), 32'd0);
        check_val("busy_after_rsp", 32'(busy), 32'd0);
        check_val("rsp_data_hold", 32'(rsp_data), 32'(e_data));
        check_val("locked", 32'(locked), 32'(e_lock || m_locked));
        if (e_lock) m_locked = 1'b1;
    endtask

    task automatic drain_lock();
        int n;
        check_val("lock_blocks_req0", 32'(req0_ready), 32'd0);
        run_txn(1'b1, 1'b1, ID_W'($urandom), ADDR_W'($urandom), 1'b0);
        n = 0;
        while (locked && n < LOCK_CYCLES + 100) begin
            @(negedge clock);
            n++;
        end
        #1;
        check_val("lock_len", 32'(last_lock_len), 32'(LOCK_CYCLES));
        check_val("lock_release", 32'(locked), 32'd0);
        m_locked = 1'b0;
        check_val("req0_ready_after_lock", 32'(req0_ready), 32'd1);
    endtask

    task automatic txn(input bit v0, input bit v1, input logic [ID_W-1:0] id,
                       input logic [ADDR_W-1:0] addr, input bit chk_walk);
        run_txn(v0, v1, id, addr, chk_walk);
        if (m_locked) drain_lock();
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        m_last = 1; m_fail = 0; m_locked = 1'b0;
    endtask

    initial begin
        int n, r;
        bit saw;
        logic [ID_W-1:0] pool [4];
        logic [ID_W-1:0] id;
        bit v0, v1;
        pool = '{16'hBEEF, 16'h0001, 16'hFFFF, 16'h8000};
        rom_mem = '{16'h1111, 16'h0000, 16'hBEEF, 16'hA5C3,
                    16'h0000, 16'h5A5A, 16'hBEEF, 16'h7777};

        // Reset state.
        repeat (2) @(negedge clock);
        #1;
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_req0_ready", 32'(req0_ready), 32'd1);
        check_val("rst_req1_ready", 32'(req1_ready), 32'd1);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_rsp_fields", {rsp_data, 13'(rsp_index), rsp_hit, rsp_port, rom_addr[0]}, 32'd0);
        rst = 1'b0;

        txn(1'b1, 1'b0, 16'hA5C3, 3'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h1234, 3'd0, 1'b1);
        txn(1'b1, 1'b0, 16'hBEEF, 3'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
        txn(1'b0, 1'b1, 16'h0000, 3'd6, 1'b0);

        // After reset a tie goes to port 0; held port-1 request follows right after RESP.
        do_reset();
        @(negedge clock);
        req0_valid = 1'b1; req1_valid = 1'b1; req0_id = 16'h5A5A; req1_addr = 3'd5;
        #1;
        check_val("tie_req0_ready", 32'(req0_ready), 32'd1);
        wait_rsp(1'b1, n);
        check_val("tie_latency", 32'(n), 32'd8);
        check_val("tie_port", 32'(rsp_port), 32'd0);
        check_val("tie_index", 32'(rsp_index), 32'd5);
        @(negedge clock);
        #1;
        check_val("tie_req1_ready", 32'(req1_ready), 32'd1);
        wait_rsp(1'b0, n);
        check_val("rd_latency", 32'(n), 32'd3);
        check_val("rd_port", 32'(rsp_port), 32'd1);
        check_val("rd_hit", 32'(rsp_hit), 32'd1);
        check_val("rd_data", 32'(rsp_data), 32'(rom_mem[5]));
        m_last = 1;
        @(negedge clock);

        // Miss count: a hit in between clears it; third consecutive miss locks (if built in).
        txn(1'b1, 1'b0, 16'h1234, 3'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h4321, 3'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h7777, 3'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h1234, 3'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h4321, 3'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h9999, 3'd0, 1'b0);

        // Reset in the middle of a scan abandons it.
        @(negedge clock);
        req0_valid = 1'b1; req0_id = 16'h1234;
        #1;
        check_val("mid_rst_accept", 32'(req0_ready), 32'd1);
        saw = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            if (k == 1) req0_valid = 1'b0;
            if (k == 4) rst = 1'b1;
            if (k == 5) rst = 1'b0;
            if (rsp_valid) saw = 1'b1;
            if (k == 6) begin
                #1;
                check_val("mid_rst_busy", 32'(busy), 32'd0);
                check_val("mid_rst_req0_ready", 32'(req0_ready), 32'd1);
            end
        end
        check_val("mid_rst_no_rsp", 32'(saw), 32'd0);
        m_last = 1; m_fail = 0; m_locked = 1'b0;

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            if (it % 10 == 0) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    r = $urandom_range(0, 3);
                    rom_mem[i] = (r == 0) ? 16'h0000 :
                                 (r == 1) ? pool[$urandom_range(0, 3)] : ID_W'($urandom);
                end
            end
            r = $urandom_range(0, 3);
            id = (r == 0) ? rom_mem[$urandom_range(0, NUM_ENTRIES - 1)] :
                 (r == 1) ? ID_W'($urandom) :
                 (r == 2) ? 16'h0000 : pool[$urandom_range(0, 3)];
            r = $urandom_range(0, 2);
            v0 = (r != 1);
            v1 = (r != 0);
            txn(v0, v1, id, ADDR_W'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
